// File: rtl/counter_pkg.sv
// Shared constants and direction encoding for the up/down counter family.
package counter_pkg;

  localparam int     COUNTER_DEFAULT_WIDTH    = 8;
  localparam longint COUNTER_DEFAULT_MODULUS  = 256;
  localparam int     COUNTER_DEFAULT_PRESCALE = 1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_prescaler.sv
// Divides qualified cycles (inc) by PRESCALE; tick marks the PRESCALE-th one.
// For PRESCALE=1 the register collapses to a constant and tick follows inc.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic          terminal;

  assign terminal = (cnt == LAST);
  assign tick     = inc & terminal;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= terminal ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/counter_updown_param.sv
// Parameterised modulo up/down counter with load, clock enable and prescaler.
// Define COUNTER_SATURATE_EN to saturate at 0 / MODULUS-1 instead of wrapping.
module counter_updown_param
  import counter_pkg::*;
#(
  parameter int     WIDTH    = COUNTER_DEFAULT_WIDTH,
  parameter longint MODULUS  = COUNTER_DEFAULT_MODULUS,
  parameter longint INIT     = 0,
  parameter int     PRESCALE = COUNTER_DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  // One extra bit so MODULUS=2**WIDTH and the borrow below zero stay visible.
  localparam int               XW     = WIDTH + 1;
  localparam logic [XW-1:0]    MOD_X  = XW'(MODULUS);
  localparam logic [XW-1:0]    MAX_X  = XW'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_Q = WIDTH'(INIT);

  dir_e             dir_s;
  logic             tick;
  logic [XW-1:0]    d_x;
  logic [XW-1:0]    step_x;
  logic             at_limit;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;

  assign dir_s = dir_e'(dir);
  assign d_x   = {1'b0, d};

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (ce & load),
    .inc  (ce & en),
    .tick (tick)
  );

  // Up overflows exactly onto MODULUS; down from 0 borrows into the top bit.
  assign step_x   = (dir_s == DIR_UP) ? {1'b0, q} + XW'(1) : {1'b0, q} - XW'(1);
  assign at_limit = (step_x == MOD_X) | step_x[XW-1];

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (load) begin
      q_next = (d_x >= MOD_X) ? MAX_Q : d;
    end else if (tick) begin
`ifdef COUNTER_SATURATE_EN
      if (!at_limit) begin
        q_next  = step_x[WIDTH-1:0];
        tc_next = (dir_s == DIR_UP) ? (step_x == MAX_X) : (step_x == '0);
      end
`else
      if (at_limit) begin
        q_next  = (dir_s == DIR_UP) ? '0 : MAX_Q;
        tc_next = 1'b1;
      end else begin
        q_next  = step_x[WIDTH-1:0];
      end
`endif
    end
  end

  // With ce low nothing is written, so a tc pulse is stretched until ce returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q  <= INIT_Q;
      tc <= 1'b0;
    end else if (ce) begin
      q  <= q_next;
      tc <= tc_next;
    end
  end

endmodule

// File: tb/tb_counter_updown_param.sv
// Scoreboard bench: three counter configurations share one stimulus stream.
module tb_counter_updown_param;

  logic       clk = 1'b0;
  logic       reset, ce, en, dir, load;
  logic [7:0] d;
  logic [7:0] qa, qb, qc;
  logic       tca, tcb, tcc;

  int total = 0;
  int bad   = 0;

  // A: mod 10 no prescale; B: mod 10 prescale 3 init 2; C: full 8-bit range init 250
  counter_updown_param #(.WIDTH(8), .MODULUS(10), .INIT(0), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .en(en), .dir(dir), .load(load), .d(d), .q(qa), .tc(tca));
  counter_updown_param #(.WIDTH(8), .MODULUS(10), .INIT(2), .PRESCALE(3)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .en(en), .dir(dir), .load(load), .d(d), .q(qb), .tc(tcb));
  counter_updown_param #(.WIDTH(8), .MODULUS(256), .INIT(250), .PRESCALE(1)) dut_c (
    .clk(clk), .reset(reset), .ce(ce), .en(en), .dir(dir), .load(load), .d(d), .q(qc), .tc(tcc));

  always #5 clk = ~clk;

  typedef struct packed {
    int q;
    bit tc;
    int pre;
  } st_t;

  typedef struct packed {
    logic [7:0] qa; logic tca;
    logic [7:0] qb; logic tcb;
    logic [7:0] qc; logic tcc;
  } exp_t;

  st_t  sa, sb, sc;
  exp_t sboard[$];

  function automatic st_t model_step(st_t s, int prescale, int modulus);
    st_t n;
    n = s;
    if (!ce) return s;
    n.tc = 1'b0;
    if (load) begin
      n.q   = (int'(d) >= modulus) ? modulus - 1 : int'(d);
      n.pre = 0;
    end else if (en) begin
      if (s.pre == prescale - 1) begin
        n.pre = 0;
`ifdef COUNTER_SATURATE_EN
        if (dir && s.q != modulus - 1) begin
          n.q = s.q + 1; n.tc = (n.q == modulus - 1);
        end else if (!dir && s.q != 0) begin
          n.q = s.q - 1; n.tc = (n.q == 0);
        end
`else
        if (dir) begin
          n.q = (s.q == modulus - 1) ? 0 : s.q + 1; n.tc = (s.q == modulus - 1);
        end else begin
          n.q = (s.q == 0) ? modulus - 1 : s.q - 1; n.tc = (s.q == 0);
        end
`endif
      end else begin
        n.pre = s.pre + 1;
      end
    end
    return n;
  endfunction

  function automatic void model_reset();
    sa = '{q: 0,   tc: 1'b0, pre: 0};
    sb = '{q: 2,   tc: 1'b0, pre: 0};
    sc = '{q: 250, tc: 1'b0, pre: 0};
  endfunction

  // Push the predicted post-edge outputs, clock once, then score the DUTs.
  task automatic cycle(input string tag);
    exp_t e;
    sa = model_step(sa, 1, 10);
    sb = model_step(sb, 3, 10);
    sc = model_step(sc, 1, 256);
    e = '{qa: sa.q[7:0], tca: sa.tc, qb: sb.q[7:0], tcb: sb.tc, qc: sc.q[7:0], tcc: sc.tc};
    sboard.push_back(e);
    @(posedge clk);
    #1;
    e = sboard.pop_front();
    total++;
    if ({qa, tca} !== {e.qa, e.tca}) begin
      bad++;
      $display("FAIL %s/a: got q=%0d tc=%0b want q=%0d tc=%0b", tag, qa, tca, e.qa, e.tca);
    end
    total++;
    if ({qb, tcb} !== {e.qb, e.tcb}) begin
      bad++;
      $display("FAIL %s/b: got q=%0d tc=%0b want q=%0d tc=%0b", tag, qb, tcb, e.qb, e.tcb);
    end
    total++;
    if ({qc, tcc} !== {e.qc, e.tcc}) begin
      bad++;
      $display("FAIL %s/c: got q=%0d tc=%0b want q=%0d tc=%0b", tag, qc, tcc, e.qc, e.tcc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; d = '0;
    #3;
    total++;
    if ({qa, tca, qb, tcb, qc, tcc} !== {8'd0, 1'b0, 8'd2, 1'b0, 8'd250, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got a=%0d/%0b b=%0d/%0b c=%0d/%0b want 0/0 2/0 250/0",
               qa, tca, qb, tcb, qc, tcc);
    end
    ce = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({qa, qb, qc} !== {8'd0, 8'd2, 8'd250}) begin
      bad++;
      $display("FAIL reset_held: got a=%0d b=%0d c=%0d want 0 2 250", qa, qb, qc);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_count_up();
    ce = 1'b1; en = 1'b1; dir = 1'b1; load = 1'b0;
    for (int i = 0; i < 10; i++) cycle("up");
    total++;
    if ({qa, tca} !== {8'd0, 1'b1}) begin
      bad++;
      $display("FAIL up_wrap: got q=%0d tc=%0b want q=0 tc=1", qa, tca);
    end
    cycle("up_after");
    total++;
    if ({qa, tca} !== {8'd1, 1'b0}) begin
      bad++;
      $display("FAIL up_tc_clear: got q=%0d tc=%0b want q=1 tc=0", qa, tca);
    end
  endtask

  task automatic test_count_down();
    load = 1'b1; d = 8'd0;
    cycle("down_load");
    load = 1'b0; dir = 1'b0;
    cycle("down_wrap");
    total++;
    if ({qa, tca} !== {8'd9, 1'b1}) begin
      bad++;
      $display("FAIL down_wrap: got q=%0d tc=%0b want q=9 tc=1", qa, tca);
    end
    for (int i = 0; i < 3; i++) cycle("down");
    total++;
    if ({qa, tca} !== {8'd6, 1'b0}) begin
      bad++;
      $display("FAIL down_steps: got q=%0d tc=%0b want q=6 tc=0", qa, tca);
    end
  endtask

  task automatic test_prescale();
    dir = 1'b1; load = 1'b1; d = 8'd0;
    cycle("pre_load");
    load = 1'b0;
    cycle("pre_1");
    cycle("pre_2");
    cycle("pre_3");
    total++;
    if (qb !== 8'd1) begin
      bad++;
      $display("FAIL pre_third_edge: got q=%0d want q=1", qb);
    end
    cycle("pre_mid");
    en = 1'b0;
    cycle("pre_gap");
    cycle("pre_gap");
    en = 1'b1;
    cycle("pre_resume");
    total++;
    if (qb !== 8'd1) begin
      bad++;
      $display("FAIL pre_delayed_early: got q=%0d want q=1", qb);
    end
    cycle("pre_resume");
    total++;
    if (qb !== 8'd2) begin
      bad++;
      $display("FAIL pre_delayed_step: got q=%0d want q=2", qb);
    end
  endtask

  task automatic test_load();
    en = 1'b0; load = 1'b1; d = 8'd15;
    cycle("load_clamp");
    total++;
    if ({qa, tca, qc} !== {8'd9, 1'b0, 8'd15}) begin
      bad++;
      $display("FAIL load_clamp: got a=%0d tc=%0b c=%0d want a=9 tc=0 c=15", qa, tca, qc);
    end
    ce = 1'b0; d = 8'd3;
    cycle("load_ce_low");
    total++;
    if (qa !== 8'd9) begin
      bad++;
      $display("FAIL load_ce_low: got q=%0d want q=9", qa);
    end
    ce = 1'b1; load = 1'b0; en = 1'b1; dir = 1'b1;
    cycle("tc_pulse");
    ce = 1'b0;
    cycle("tc_hold");
    cycle("tc_hold");
    total++;
    if ({qa, tca} !== {8'd0, 1'b1}) begin
      bad++;
      $display("FAIL tc_hold_ce_low: got q=%0d tc=%0b want q=0 tc=1", qa, tca);
    end
    ce = 1'b1;
    cycle("tc_release");
  endtask

  task automatic test_reset_midcount();
    ce = 1'b1; en = 1'b1; dir = 1'b1; load = 1'b0;
    for (int i = 0; i < 4; i++) cycle("pre_reset");
    load = 1'b1; d = 8'd7;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({qa, tca, qb, tcb, qc, tcc} !== {8'd0, 1'b0, 8'd2, 1'b0, 8'd250, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got a=%0d/%0b b=%0d/%0b c=%0d/%0b want 0/0 2/0 250/0",
               qa, tca, qb, tcb, qc, tcc);
    end
    #2 reset = 1'b0;
    load = 1'b0;
    model_reset();
    cycle("post_reset");
    cycle("post_reset");
    total++;
    if (qb !== 8'd2) begin
      bad++;
      $display("FAIL post_reset_early: got q=%0d want q=2", qb);
    end
    cycle("post_reset");
    total++;
    if (qb !== 8'd3) begin
      bad++;
      $display("FAIL post_reset_first_step: got q=%0d want q=3", qb);
    end
  endtask

  task automatic test_dir_change();
    for (int i = 0; i < 12; i++) begin
      dir = (i % 3) != 0;
      cycle("dir_change");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      ce   = ($urandom % 8) != 0;
      en   = ($urandom % 4) != 0;
      dir  = $urandom % 2;
      load = ($urandom % 8) == 0;
      d    = 8'($urandom_range(0, 255));
      cycle("random");
    end
    ce = 1'b1; load = 1'b0;
  endtask

`ifdef COUNTER_SATURATE_EN
  task automatic test_saturate();
    ce = 1'b1; en = 1'b1; dir = 1'b1; load = 1'b1; d = 8'd8;
    cycle("sat_load");
    load = 1'b0;
    cycle("sat_reach");
    total++;
    if ({qa, tca} !== {8'd9, 1'b1}) begin
      bad++;
      $display("FAIL sat_reach: got q=%0d tc=%0b want q=9 tc=1", qa, tca);
    end
    for (int i = 0; i < 5; i++) begin
      cycle("sat_hold");
      total++;
      if ({qa, tca} !== {8'd9, 1'b0}) begin
        bad++;
        $display("FAIL sat_hold: got q=%0d tc=%0b want q=9 tc=0", qa, tca);
      end
    end
    dir = 1'b0;
    cycle("sat_down");
    total++;
    if (qa !== 8'd8) begin
      bad++;
      $display("FAIL sat_down: got q=%0d want q=8", qa);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_prescale();
    test_load();
    test_reset_midcount();
    test_dir_change();
    test_back_to_back();
`ifdef COUNTER_SATURATE_EN
    test_saturate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
